// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 door-lock keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_e;

    // Rows 0..2 are the digit rows 1-9; row 3 holds '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                2'd2:    code = KEY_HASH;
                default: code = 4'h0;
            endcase
        end else begin
            code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan press/release debouncer: turns a stream of scan results into one
// key_valid strobe per accepted press and a held flag until release is confirmed.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_SCANS = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      scan_done_i,
    input  scan_res_e result_i,
    input  logic [3:0] code_i,
    output logic [3:0] key_code_o,
    output logic      key_valid_o,
    output logic      key_held_o
);

    localparam int CW = $clog2(DEB_SCANS + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEB_SCANS);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    // Next-state logic, advanced only on the cycle a full scan completes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        cnt_inc_s   = cnt_q + CNT_ONE;
        if (scan_done_i) begin
            case (state_q)
                IDLE: begin
                    if (result_i == RES_SINGLE) begin
                        state_d = DEBOUNCE;
                        cand_d  = code_i;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                DEBOUNCE: begin
                    if ((result_i == RES_SINGLE) && (code_i == cand_q)) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            state_d     = HELD;
                            cnt_d       = CNT_ZERO;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else if (result_i == RES_SINGLE) begin
                        cand_d = code_i;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                HELD: begin
                    if (result_i == RES_NONE) begin
                        state_d = RELEASE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                RELEASE: begin
                    if (result_i == RES_NONE) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            state_d = IDLE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = CNT_ZERO;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        key_held_d = (state_d == HELD) || (state_d == RELEASE);
    end

    // FSM and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: strobes columns, samples synchronized rows at the end of
// each column dwell and classifies each full scan before debouncing.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 10000,
    parameter int DEB_SCANS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    output logic [3:0]          key_code_o,
    output logic                key_valid_o,
    output logic                key_held_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [NUM_COLS-1:0] col_q, col_d, col_nxt_s;
    logic [1:0]          hits_q, hits_d, hits_acc_s;
    logic [3:0]          code_q, code_d, code_acc_s;
    logic [2:0]          row_ones_s, hits_sum_s;
    logic [1:0]          row_idx_s, col_idx_s;
    logic                last_dwell_s, scan_done_s;
    scan_res_e           result_s;

    // Hit accounting: hits saturates at 2, which is all the classifier needs.
    always_comb begin
        row_ones_s = 3'd0;
        row_idx_s  = 2'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_ones_s = row_ones_s + {2'b00, row_sync_q[r]};
            if (row_sync_q[r]) begin
                row_idx_s = 2'(r);
            end else begin
                row_idx_s = row_idx_s;
            end
        end
        case (col_q)
            3'b001:  begin col_idx_s = 2'd0; col_nxt_s = 3'b010; end
            3'b010:  begin col_idx_s = 2'd1; col_nxt_s = 3'b100; end
            3'b100:  begin col_idx_s = 2'd2; col_nxt_s = 3'b001; end
            default: begin col_idx_s = 2'd0; col_nxt_s = 3'b001; end
        endcase
        last_dwell_s = (dwell_q == DWELL_LAST);
        scan_done_s  = last_dwell_s && col_q[NUM_COLS-1];
        hits_sum_s   = {1'b0, hits_q} + row_ones_s;
        hits_acc_s   = (hits_sum_s >= 3'd2) ? 2'd2 : hits_sum_s[1:0];
        if ((hits_q == 2'd0) && (row_ones_s == 3'd1)) begin
            code_acc_s = key_map(row_idx_s, col_idx_s);
        end else begin
            code_acc_s = code_q;
        end
        case (hits_acc_s)
            2'd0:    result_s = RES_NONE;
            2'd1:    result_s = RES_SINGLE;
            default: result_s = RES_MULTI;
        endcase
        if (last_dwell_s) begin
            dwell_d = {DW{1'b0}};
            col_d   = col_nxt_s;
            hits_d  = scan_done_s ? 2'd0 : hits_acc_s;
            code_d  = scan_done_s ? 4'h0 : code_acc_s;
        end else begin
            dwell_d = dwell_q + DWELL_ONE;
            col_d   = col_q;
            hits_d  = hits_q;
            code_d  = code_q;
        end
    end

    // Row synchronizer, dwell counter, column rotation and partial-scan state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_meta_q <= {NUM_ROWS{1'b0}};
            row_sync_q <= {NUM_ROWS{1'b0}};
            dwell_q    <= {DW{1'b0}};
            col_q      <= 3'b001;
            hits_q     <= 2'd0;
            code_q     <= 4'h0;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
            col_q      <= col_d;
            hits_q     <= hits_d;
            code_q     <= code_d;
        end
    end

    assign col_o = col_q;

    keypad_debounce #(
        .DEB_SCANS (DEB_SCANS)
    ) u_debounce (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scan_done_i (scan_done_s),
        .result_i    (result_s),
        .code_i      (code_acc_s),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEB_SCANS=3 (12-clock scan);
// the keypad is modelled as row = f(col, pressed keys).
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [11:0] keys = 12'h000;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    localparam int K1 = 0, K5 = 4, K7 = 6, K9 = 8, KSTAR = 9, K0 = 10, KHASH = 11;

    keypad_scan #(.SCAN_DIV(4), .DEB_SCANS(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .row_i       (row),
        .col_o       (col),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_held_o  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && col[c]) row[r] = 1'b1;
    end

    always @(posedge clk) begin
        if (key_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic wait_pulse(input int max_cyc, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic sync_to_scan(output bit found);
        logic [2:0] prev;
        found = 1'b0;
        prev = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 3'b100 && col == 3'b001) begin
                found = 1'b1;
                break;
            end
            prev = col;
        end
    endtask

    task automatic test_reset();
        int p0;
        logic [2:0] exp_col;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (col !== 3'b001) begin fails++; $display("FAIL reset_col: got %b expected 001", col); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h expected 0", key_code); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b expected 0", key_held); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_col = 3'b001 << ((k / 4) % 3);
            tests++; if (col !== exp_col) begin fails++; $display("FAIL col_rotate k=%0d: got %b expected %b", k, col, exp_col); end
            @(negedge clk);
        end
        p0 = pulse_cnt;
        repeat (200) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", pulse_cnt - p0); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL idle_code: got %h expected 0", key_code); end
    endtask

    task automatic test_press_5();
        int p0, lat; bit got;
        p0 = pulse_cnt;
        keys[K5] = 1'b1;
        wait_pulse(60, lat, got);
        tests++; if (!got || lat > 51) begin fails++; $display("FAIL press5_latency: got %0d (seen=%0b) expected <=51", lat, got); end
        tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL press5_code: got %h expected 5", key_code); end
        repeat (100 - lat) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL press5_pulses: got %0d expected 1", pulse_cnt - p0); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press5_held: got %b expected 1", key_held); end
        keys = 12'h000;
        repeat (24) @(negedge clk);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press5_held_2scans: got %b expected 1", key_held); end
        repeat (28) @(negedge clk);
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL press5_released: got %b expected 0", key_held); end
        tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL press5_code_kept: got %h expected 5", key_code); end
    endtask

    task automatic test_bounce_hash();
        int p0, lat; bit got, found;
        p0 = pulse_cnt;
        sync_to_scan(found);
        tests++; if (!found) begin fails++; $display("FAIL bounce_sync: scan start seen=%0b expected 1", found); end
        keys[KHASH] = 1'b1;
        repeat (12) @(negedge clk);
        keys = 12'h000;
        repeat (12) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL bounce_no_pulse: got %0d expected 0", pulse_cnt - p0); end
        keys[KHASH] = 1'b1;
        wait_pulse(60, lat, got);
        tests++; if (!got) begin fails++; $display("FAIL bounce_pulse: seen=%0b expected 1", got); end
        tests++; if (key_code !== 4'hB) begin fails++; $display("FAIL bounce_code: got %h expected b", key_code); end
        repeat (60) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_cnt - p0); end
        keys = 12'h000;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_multi_then_0();
        int p0, lat; bit got;
        p0 = pulse_cnt;
        keys[K1] = 1'b1;
        keys[K9] = 1'b1;
        repeat (100) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL multi_no_pulse: got %0d expected 0", pulse_cnt - p0); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL multi_held: got %b expected 0", key_held); end
        keys = 12'h000;
        keys[K0] = 1'b1;
        wait_pulse(60, lat, got);
        tests++; if (!got) begin fails++; $display("FAIL key0_pulse: seen=%0b expected 1", got); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL key0_code: got %h expected 0", key_code); end
        repeat (40) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL key0_pulses: got %0d expected 1", pulse_cnt - p0); end
        keys = 12'h000;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_back_to_back_star();
        int p0, lat; bit got, found;
        p0 = pulse_cnt;
        keys[KSTAR] = 1'b1;
        wait_pulse(60, lat, got);
        tests++; if (!got || key_code !== 4'hA) begin fails++; $display("FAIL star1: got code %h seen=%0b expected a", key_code, got); end
        sync_to_scan(found);
        keys = 12'h000;
        repeat (24) @(negedge clk);
        keys[KSTAR] = 1'b1;
        repeat (60) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL star_short_release: got %0d pulses expected 1", pulse_cnt - p0); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL star_still_held: got %b expected 1", key_held); end
        keys = 12'h000;
        repeat (60) @(negedge clk);
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL star_released: got %b expected 0", key_held); end
        keys[KSTAR] = 1'b1;
        wait_pulse(60, lat, got);
        @(negedge clk);
        tests++; if (!got || pulse_cnt - p0 !== 2) begin fails++; $display("FAIL star2_pulses: got %0d expected 2", pulse_cnt - p0); end
        tests++; if (key_code !== 4'hA) begin fails++; $display("FAIL star2_code: got %h expected a", key_code); end
        keys = 12'h000;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce();
        int p0, lat; bit got, found;
        sync_to_scan(found);
        keys[K7] = 1'b1;
        repeat (24) @(negedge clk);
        p0 = pulse_cnt;
        rst = 1'b1;
        #1;
        tests++; if (col !== 3'b001) begin fails++; $display("FAIL rst_mid_col: got %b expected 001", col); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL rst_mid_code: got %h expected 0", key_code); end
        tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL rst_mid_flags: got valid=%b held=%b expected 0 0", key_valid, key_held); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_pulse(70, lat, got);
        tests++; if (!got || lat < 24 || lat > 51) begin fails++; $display("FAIL rst_mid_latency: got %0d seen=%0b expected 24..51", lat, got); end
        tests++; if (key_code !== 4'h7) begin fails++; $display("FAIL rst_mid_code7: got %h expected 7", key_code); end
        repeat (30) @(negedge clk);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL rst_mid_pulses: got %0d expected 1", pulse_cnt - p0); end
        keys = 12'h000;
    endtask

    initial begin
        test_reset();
        test_press_5();
        test_bounce_hash();
        test_multi_then_0();
        test_back_to_back_star();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the door-lock 4×3 keypad by strobing its three column lines in turn and sampling its four row lines, the input-side counterpart of the time-multiplexed 7-segment driver. It resolves one pressed key per debounced press and emits a 4-bit key code with a single-cycle valid strobe to the lock controller. It provides no auto-repeat: each physical press yields exactly one strobe.

## Interface
- SCAN_DIV, 10000: clocks each column stays driven; must be ≥ 4.
- DEB_SCANS, 4: consecutive identical full scans needed to accept a press or a release; must be ≥ 2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- row  in  4  keypad row sense from pins, active-high (pulled low externally), asynchronous to clk.
- col  out  3  column drive, one-hot, active-high; col[0] is the leftmost column.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle strobe when a press is accepted.
- key_held  out  1  high while an accepted key has not been released.

## Operation
- Key map, rows top to bottom, columns left to right:
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: * = 4'hA, 0 = 4'h0, # = 4'hB
- The `row` input passes through a 2-flop synchronizer.
- Dwell counter counts 0..SCAN_DIV-1; col advances 001→010→100→001 when it wraps.
- Synchronized rows are sampled in the last dwell cycle of each column.
- A full scan is col0..col2, lasting 3·SCAN_DIV clocks. At its end the scan result is classified:
  - NONE: no row high in any column.
  - SINGLE(code): exactly one row high in exactly one column.
  - MULTI: anything else.
- FSM, evaluated once per scan end:
  - IDLE: SINGLE → DEBOUNCE, cand=code, cnt=1. Otherwise stay in IDLE.
  - DEBOUNCE: SINGLE equal to cand → cnt+1. When cnt reaches DEB_SCANS: pulse key_valid, load key_code=cand, go to HELD. SINGLE with a different code → restart DEBOUNCE with cand=new code, cnt=1. NONE or MULTI → IDLE.
  - HELD: NONE → RELEASE, cnt=1. Otherwise stay in HELD.
  - RELEASE: NONE → cnt+1; at DEB_SCANS go to IDLE. Any SINGLE or MULTI → HELD. This branch never pulses key_valid.
- key_held = (state == HELD or RELEASE).
- key_code keeps its value until the next accepted press.
- Reset mid-operation, at any state: FSM returns to IDLE, the counters and the partial scan are discarded, and no key_valid is emitted.

## Timing
- Reset values: col=3'b001, key_code=4'h0, key_valid=0, key_held=0, state IDLE, dwell=0, cnt=0.
- The first scan after reset starts at col0, dwell 0.
- key_valid is registered and asserted for exactly one clock, the cycle after the scan end that completes the count. key_code and key_held update in that same cycle.
- Press latency from stable pins: ≤ (DEB_SCANS+1)·3·SCAN_DIV + 3 clocks, and ≥ (DEB_SCANS−1)·3·SCAN_DIV.
- Release must stay stable for DEB_SCANS full scans before a new press can be accepted.
- Settling: rows are sampled SCAN_DIV−1 clocks after a column change, so 2 synchronizer cycles plus ≥1 settle cycle are guaranteed by SCAN_DIV ≥ 4.
- cnt width is $clog2(DEB_SCANS+1); dwell width is $clog2(SCAN_DIV). Neither counter may wrap inside a state.

## Structure
- Package keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=3
  - the state enum {IDLE, DEBOUNCE, HELD, RELEASE}
  - key code constants KEY_STAR=4'hA, KEY_HASH=4'hB
  - the row/col → code mapping function
- Top keypad_scan contains the synchronizer, dwell counter, column rotation and per-scan classifier.
- Sub-module keypad_debounce contains the FSM, cnt, key_code/key_valid/key_held registers, and a one-cycle scan_done input with result/code.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_SCANS=3, giving a 12-clock scan; the bench models the keypad as row = f(col, pressed keys).
- Reset, no keys pressed → col cycles 001/010/100 every 4 clocks; key_valid never asserts over 200 clocks; key_code=0.
- Press '5' (row1/col1) held 100 clocks → exactly one key_valid pulse, key_code=4'h5, within 51 clocks of press; key_held=1 until 3 scans after release.
- Press '#' with a 2-scan bounce (pressed 1 scan, open 1 scan, then stable) → single pulse, key_code=4'hB; no pulse during the bounce.
- Press '1' and '9' simultaneously for 100 clocks → no key_valid; release both, then press '0' → one pulse, key_code=4'h0.
- Press '*', release for only 2 scans, press '*' again → only one pulse in total. After a full 3-scan release, a new press gives a second pulse with code 4'hA.
- Assert rst during DEBOUNCE for '7' → outputs return to reset values immediately; after release, scanning restarts at col=001 and '7', still held, yields one pulse ≥ 24 clocks later.
